switch_conditioner: RTL and testbench
=====================================

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, on ports clk and rst_n.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the number of slide-switch inputs conditioned.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (10 ms at 100 MHz), giving the consecutive stable cycles required to accept a change; legal minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit: 100 MHz board clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port sw_raw, input, WIDTH bits: raw asynchronous slide-switch levels.
REQ-007 The block SHALL have port sw_clean, output, WIDTH bits: synchronized, debounced switch levels for the LED controller and clock divider.
REQ-008 The block SHALL have port sw_rise, output, WIDTH bits: one-cycle pulse per bit when sw_clean goes 0->1 (macro-dependent, REQ-022).
REQ-009 The block SHALL have port sw_fall, output, WIDTH bits: one-cycle pulse per bit when sw_clean goes 1->0 (macro-dependent, REQ-022).
REQ-010 The block SHALL have port cfg_changed, output, 1 bit: one-cycle pulse when any sw_clean bit changes.

Function
REQ-011 Each sw_raw bit SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-012 Each bit SHALL have an independent counter of width $clog2(DEBOUNCE_CYCLES+1) and a two-state FSM: STABLE (synchronized value equals sw_clean, counter held at 0) and PENDING (values differ, counter increments each cycle).
REQ-013 In PENDING, if the synchronized value returns to equal sw_clean, the FSM SHALL go to STABLE and the counter SHALL clear, with no output change.
REQ-014 In PENDING, when the counter reaches DEBOUNCE_CYCLES-1, on the next edge sw_clean SHALL take the synchronized value, the counter SHALL clear and the FSM SHALL go to STABLE.
REQ-015 Latency: a clean raw transition held steady SHALL appear on sw_clean exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change sw_clean.
REQ-017 sw_rise, sw_fall and cfg_changed SHALL assert in the same cycle sw_clean updates and SHALL last exactly one cycle.
REQ-018 Simultaneous qualifying changes on several bits SHALL update all those bits and their pulses in the same cycle, with a single one-cycle cfg_changed.
REQ-019 The counter SHALL saturate-free: it never exceeds DEBOUNCE_CYCLES-1 and never wraps.

Reset
REQ-020 While rst_n=0 (asynchronous assert), synchronizer flops, counters, sw_clean, sw_rise, sw_fall and cfg_changed SHALL all be 0 and every FSM SHALL be in STABLE; release is synchronous to clk through the design's own flops.
REQ-021 A switch held high through reset SHALL produce a normal debounced 0->1 transition with sw_rise and cfg_changed pulses DEBOUNCE_CYCLES+2 edges after release; reset mid-PENDING SHALL discard the pending change.

Configuration
REQ-022 With macro SW_EDGE_PULSE_EN defined, sw_rise and sw_fall SHALL behave per REQ-017; without it, both SHALL be tied to 0 and their edge-detect logic SHALL be absent (cfg_changed unaffected).

Structure
REQ-023 A shared package switch_cond_pkg SHALL hold the FSM state typedef (STABLE, PENDING), the default DEBOUNCE_CYCLES constant and the default WIDTH constant.
REQ-024 Per-bit synchronizer, FSM and counter SHALL be one sub-module, sw_debounce_bit, instantiated WIDTH times by generate; the top SHALL hold only pulse aggregation.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8)
REQ-025 Reset: sw_raw=8'hFF during rst_n=0 -> all outputs 0; after release, sw_clean=8'hFF on edge 6 with sw_rise=8'hFF and cfg_changed pulsing one cycle.
REQ-026 Glitch: bit 2 high for 3 cycles then low -> sw_clean[2] stays 0; no pulses.
REQ-027 Clean change: bit 1 0->1 held -> sw_clean[1]=1 exactly 6 edges later; sw_rise[1] one cycle; bit 1 1->0 -> sw_fall[1] one cycle.
REQ-028 Simultaneous: bits 0 and 7 change in the same cycle -> both update together, single cfg_changed pulse.
REQ-029 Reset mid-PENDING: bit 3 rises, rst_n pulsed low at edge 4 -> sw_clean[3]=0 immediately, then rises 6 edges after release.
REQ-030 Macro off: repeat REQ-027 without SW_EDGE_PULSE_EN -> sw_rise/sw_fall stay 0; sw_clean and cfg_changed identical.

Source files
------------

// File: rtl/switch_cond_pkg.sv
// Shared definitions for the slide-switch conditioner.
//   db_state_t              : per-bit debounce FSM state (STABLE / PENDING)
//   DEFAULT_WIDTH           : default number of switches conditioned
//   DEFAULT_DEBOUNCE_CYCLES : default stable-cycle count (10 ms at 100 MHz)
package switch_cond_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  localparam int DEFAULT_WIDTH           = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bundle between the board pins / bench and the conditioner.
//   sw_raw      : raw asynchronous slide-switch levels (into conditioner)
//   sw_clean    : synchronized, debounced levels
//   sw_rise     : one-cycle pulse per bit on sw_clean 0->1
//   sw_fall     : one-cycle pulse per bit on sw_clean 1->0
//   cfg_changed : one-cycle pulse when any sw_clean bit changes
// Modports: master drives sw_raw and observes the rest; slave is the
// conditioner itself.
interface switch_conditioner_if
  import switch_cond_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             cfg_changed;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  cfg_changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output cfg_changed
  );
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchronizer followed by a STABLE/PENDING
// debounce FSM with its own counter.
// Ports:
//   clk   : board clock
//   rst_n : asynchronous active-low reset
//   raw   : raw asynchronous switch level
//   clean : debounced level, changes only after DEBOUNCE_CYCLES agreeing
//           synchronized samples
module sw_debounce_bit
  import switch_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_p0;
  logic          sync_p1;
  db_state_t     state;
  db_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          clean_nxt;

  // Stage p0/p1: metastability synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
    end
  end

  // The first differing cycle already counts, so entering PENDING loads 1.
  // That makes the accepted change land DEBOUNCE_CYCLES+2 edges after the
  // raw level is first sampled, and keeps cnt at most DEBOUNCE_CYCLES-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = clean;
    unique case (state)
      STABLE: begin
        cnt_nxt = '0;
        if (sync_p1 != clean) begin
          state_nxt = PENDING;
          cnt_nxt   = CNT_ONE;
        end
      end
      PENDING: begin
        if (sync_p1 == clean) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          clean_nxt = sync_p1;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/switch_conditioner.sv
// Slide-switch conditioner: WIDTH independent synchronize+debounce lanes
// plus change-pulse aggregation for the LED controller / clock divider.
// Ports:
//   clk   : 100 MHz board clock
//   rst_n : asynchronous active-low reset
//   bus   : switch_conditioner_if.slave (sw_raw in; sw_clean, sw_rise,
//           sw_fall, cfg_changed out)
// Build option: define SW_EDGE_PULSE_EN to generate sw_rise / sw_fall;
// otherwise both are tied to zero. cfg_changed is always generated.
module switch_conditioner
  import switch_cond_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  switch_conditioner_if.slave bus
);

  logic [WIDTH-1:0] clean;
  logic [WIDTH-1:0] clean_d_p0;

  // Per-bit synchronizer and debounce lanes
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (bus.sw_raw[i]),
      .clean(clean[i])
    );
  end

  // Stage p0: previous debounced value, so pulses coincide with the update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_d_p0 <= '0;
    end else begin
      clean_d_p0 <= clean;
    end
  end

  assign bus.sw_clean    = clean;
  assign bus.cfg_changed = |(clean ^ clean_d_p0);

`ifdef SW_EDGE_PULSE_EN
  assign bus.sw_rise = clean & ~clean_d_p0;
  assign bus.sw_fall = ~clean & clean_d_p0;
`else
  assign bus.sw_rise = '0;
  assign bus.sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with WIDTH=8, DEBOUNCE_CYCLES=4.
// Accepted changes appear 6 rising edges after the first edge that samples
// the new raw level. Edge-pulse expectations follow SW_EDGE_PULSE_EN.
module tb_switch_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  switch_conditioner_if #(.WIDTH(8)) bus ();

  switch_conditioner #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [7:0] edge_exp(input logic [7:0] v);
`ifdef SW_EDGE_PULSE_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c, input logic [7:0] r,
                            input logic [7:0] f, input logic g);
    chk({tag, ".clean"}, bus.sw_clean, c);
    chk({tag, ".rise"},  bus.sw_rise,  r);
    chk({tag, ".fall"},  bus.sw_fall,  f);
    chk({tag, ".cfg"},   {7'd0, bus.cfg_changed}, {7'd0, g});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all switches high
    rst_n      = 1'b0;
    bus.sw_raw = 8'hFF;
    #22;
    expect_out("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out("rel_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    expect_out("rel_edge6", 8'hFF, edge_exp(8'hFF), 8'h00, 1'b1);
    tick();
    expect_out("rel_after", 8'hFF, 8'h00, 8'h00, 1'b0);

    // All switches low
    bus.sw_raw = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out("all_low_wait", 8'hFF, 8'h00, 8'h00, 1'b0);
    end
    tick();
    expect_out("all_low_edge6", 8'h00, 8'h00, edge_exp(8'hFF), 1'b1);
    tick();
    expect_out("all_low_after", 8'h00, 8'h00, 8'h00, 1'b0);

    // Glitch: bit 2 high for 3 cycles
    bus.sw_raw = 8'h04;
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out("glitch_hi", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    bus.sw_raw = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      expect_out("glitch_lo", 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // Clean rise then fall on bit 1
    bus.sw_raw = 8'h02;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out("b1_rise_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    expect_out("b1_rise_edge6", 8'h02, edge_exp(8'h02), 8'h00, 1'b1);
    tick();
    expect_out("b1_rise_after", 8'h02, 8'h00, 8'h00, 1'b0);
    bus.sw_raw = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out("b1_fall_wait", 8'h02, 8'h00, 8'h00, 1'b0);
    end
    tick();
    expect_out("b1_fall_edge6", 8'h00, 8'h00, edge_exp(8'h02), 1'b1);
    tick();
    expect_out("b1_fall_after", 8'h00, 8'h00, 8'h00, 1'b0);

    // Simultaneous change on bits 0 and 7
    bus.sw_raw = 8'h81;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out("simul_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    expect_out("simul_edge6", 8'h81, edge_exp(8'h81), 8'h00, 1'b1);
    tick();
    expect_out("simul_after", 8'h81, 8'h00, 8'h00, 1'b0);

    // Reset while bit 3 is pending
    bus.sw_raw = 8'h89;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_out("midpend_wait", 8'h81, 8'h00, 8'h00, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    expect_out("midpend_rst", 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    expect_out("midpend_rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out("midpend_rel_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    expect_out("midpend_edge6", 8'h89, edge_exp(8'h89), 8'h00, 1'b1);
    tick();
    expect_out("midpend_after", 8'h89, 8'h00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
